// File: rtl/fifo_read_ctrl.sv
// rtl/fifo_read_ctrl.sv - FIFO read-side controller: read pointer, empty flag, registered output word
// Optional feature macro: FIFO_RD_ALMOST_EMPTY_EN adds parameter AE_LEVEL and output raempty.
module fifo_read_ctrl #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 4
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  ,
  parameter int AE_LEVEL  = 2
`endif
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic [ADDR_SIZE:0]   rq2_wptr,
  input  logic [DATA_SIZE-1:0] rdata,
  output logic [ADDR_SIZE-1:0] raddr,
  output logic [ADDR_SIZE:0]   rptr,
  output logic                 rempty,
  output logic [ADDR_SIZE:0]   rlevel,
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  output logic                 raempty,
`endif
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);

  // Convert a Gray-coded pointer back to binary (MSB down, running XOR).
  function automatic logic [ADDR_SIZE:0] gray2bin(input logic [ADDR_SIZE:0] g);
    logic [ADDR_SIZE:0] b;
    b[ADDR_SIZE] = g[ADDR_SIZE];
    for (int i = ADDR_SIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Registered state
  logic [ADDR_SIZE:0]   rbin_q, rbin_d;
  logic [ADDR_SIZE:0]   rptr_q, rptr_d;
  logic                 rempty_q, rempty_d;
  logic [ADDR_SIZE:0]   rlevel_q, rlevel_d;
  logic [DATA_SIZE-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;

  // Combinational helpers
  logic                 fetch;
  logic [ADDR_SIZE:0]   wbin;

`ifdef FIFO_RD_ALMOST_EMPTY_EN
  localparam logic [ADDR_SIZE:0] AE_LEVEL_C = AE_LEVEL[ADDR_SIZE:0];
  logic raempty_q, raempty_d;
`endif

  // Next-state: fetch only from registered empty, so a word is never read on a stale compare
  always_comb begin
    fetch       = !rempty_q && (!out_valid_q || out_ready);
    wbin        = gray2bin(rq2_wptr);
    rbin_d      = rbin_q + {{ADDR_SIZE{1'b0}}, fetch};
    rptr_d      = (rbin_d >> 1) ^ rbin_d;
    rempty_d    = (rptr_d == rq2_wptr);
    rlevel_d    = wbin - rbin_d;
    out_data_d  = fetch ? rdata : out_data_q;
    out_valid_d = fetch | (out_valid_q & ~out_ready);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    raempty_d   = (rlevel_d <= AE_LEVEL_C);
`endif
  end

  // State registers with synchronous active-high reset; any pending output word is dropped
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_q      <= '0;
      rptr_q      <= '0;
      rempty_q    <= 1'b1;
      rlevel_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
      raempty_q   <= 1'b1;
`endif
    end else begin
      rbin_q      <= rbin_d;
      rptr_q      <= rptr_d;
      rempty_q    <= rempty_d;
      rlevel_q    <= rlevel_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
      raempty_q   <= raempty_d;
`endif
    end
  end

  // Memory address is the only combinational output path
  assign raddr     = rbin_q[ADDR_SIZE-1:0];
  assign rptr      = rptr_q;
  assign rempty    = rempty_q;
  assign rlevel    = rlevel_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  assign raempty   = raempty_q;
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb/tb_fifo_read_ctrl.sv - directed self-checking bench for fifo_read_ctrl
module tb_fifo_read_ctrl;

  logic       rclk = 1'b0;
  logic       rrst;
  logic [4:0] rq2_wptr;
  logic [7:0] rdata;
  logic [3:0] raddr;
  logic [4:0] rptr;
  logic       rempty;
  logic [4:0] rlevel;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  logic       raempty;
`endif

  logic [7:0] mem [0:15];

  int n_checks = 0;
  int n_errors = 0;

  always #5 rclk = ~rclk;

  assign rdata = mem[raddr];

  fifo_read_ctrl dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .rq2_wptr  (rq2_wptr),
    .rdata     (rdata),
    .raddr     (raddr),
    .rptr      (rptr),
    .rempty    (rempty),
    .rlevel    (rlevel),
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    .raempty   (raempty),
`endif
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  function automatic logic [4:0] gray(input int n);
    logic [4:0] b;
    b = n[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic do_reset();
    rrst     = 1'b1;
    rq2_wptr = 5'b00000;
    tick();
    rrst     = 1'b0;
  endtask

  initial begin
    rrst      = 1'b1;
    rq2_wptr  = 5'b00011;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    // Reset held for 3 edges with a non-zero write pointer
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_rempty", rempty, 1);
      check("rst_valid", out_valid, 0);
      check("rst_rptr", rptr, 0);
      check("rst_raddr", raddr, 0);
      check("rst_rlevel", rlevel, 0);
      check("rst_data", out_data, 0);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
      check("rst_raempty", raempty, 1);
`endif
    end
    rq2_wptr = 5'b00000;
    tick();
    rrst = 1'b0;
    tick();
    check("idle_rempty", rempty, 1);

    // Single word
    mem[0]   = 8'hA5;
    rq2_wptr = 5'b00001;
    tick();
    check("one_rempty_fall", rempty, 0);
    check("one_valid_lat", out_valid, 0);
    check("one_rlevel1", rlevel, 1);
    tick();
    check("one_valid", out_valid, 1);
    check("one_data", out_data, 8'hA5);
    check("one_rempty", rempty, 1);
    check("one_rptr", rptr, 5'b00001);
    check("one_rlevel0", rlevel, 0);
    check("one_raddr", raddr, 1);
    out_ready = 1'b1;
    tick();
    check("one_consumed", out_valid, 0);
    check("one_hold_data", out_data, 8'hA5);

    // Streaming 16 words at one word per cycle
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = i[7:0];
    out_ready = 1'b1;
    rq2_wptr  = 5'b11000;
    tick();
    check("str_rlevel16", rlevel, 16);
    check("str_rempty", rempty, 0);
    for (int k = 0; k < 16; k++) begin
      tick();
      check("str_valid", out_valid, 1);
      check("str_data", out_data, k);
      check("str_rlevel", rlevel, 15 - k);
    end
    check("str_rptr", rptr, 5'b11000);
    check("str_rempty_end", rempty, 1);
    tick();
    check("str_drained", out_valid, 0);

    // Backpressure: 4 words, consumer stalls for 5 cycles
    do_reset();
    out_ready = 1'b0;
    rq2_wptr  = 5'b00110;
    tick();
    check("bp_rlevel4", rlevel, 4);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    check("bp_raempty4", raempty, 0);
`endif
    tick();
    check("bp_first", out_data, 0);
    check("bp_first_rptr", rptr, 5'b00001);
    check("bp_first_rlevel", rlevel, 3);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_data", out_data, 0);
      check("bp_hold_rptr", rptr, 5'b00001);
      check("bp_hold_rlevel", rlevel, 3);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
      check("bp_hold_raempty", raempty, 0);
`endif
    end
    out_ready = 1'b1;
    tick();
    check("bp_w1", out_data, 1);
    check("bp_w1_rptr", rptr, 5'b00011);
    check("bp_w1_rlevel", rlevel, 2);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    check("bp_w1_raempty", raempty, 1);
`endif
    tick();
    check("bp_w2", out_data, 2);
    check("bp_w2_rptr", rptr, 5'b00010);
    tick();
    check("bp_w3", out_data, 3);
    check("bp_w3_rptr", rptr, 5'b00110);
    check("bp_w3_rempty", rempty, 1);
    check("bp_w3_valid", out_valid, 1);
    tick();
    check("bp_drained", out_valid, 0);

    // Wrap: preset by streaming 30 words in two bursts, then 4 across the pointer wrap
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'hC0 + i[7:0];
    out_ready = 1'b1;
    rq2_wptr  = gray(15);
    tick();
    for (int n = 0; n < 15; n++) begin
      tick();
      check("wrp_pre_a", out_data, 8'hC0 + (n % 16));
    end
    rq2_wptr = gray(30);
    tick();
    for (int n = 15; n < 30; n++) begin
      tick();
      check("wrp_pre_b", out_data, 8'hC0 + (n % 16));
    end
    check("wrp_pre_rempty", rempty, 1);
    check("wrp_pre_raddr", raddr, 14);
    rq2_wptr = 5'b00011;
    tick();
    check("wrp_rlevel4", rlevel, 4);
    check("wrp_raddr14", raddr, 14);
    tick();
    check("wrp_w30", out_data, 8'hCE);
    check("wrp_raddr15", raddr, 15);
    check("wrp_rptr31", rptr, 5'b10000);
    check("wrp_rempty30", rempty, 0);
    tick();
    check("wrp_w31", out_data, 8'hCF);
    check("wrp_raddr0", raddr, 0);
    check("wrp_rptr_msb", rptr, 5'b00000);
    check("wrp_rempty31", rempty, 0);
    tick();
    check("wrp_w32", out_data, 8'hC0);
    check("wrp_rptr1", rptr, 5'b00001);
    check("wrp_rempty32", rempty, 0);
    tick();
    check("wrp_w33", out_data, 8'hC1);
    check("wrp_rempty33", rempty, 1);
    check("wrp_rlevel0", rlevel, 0);

    // Reset with a word pending discards it
    rrst = 1'b1;
    tick();
    rrst = 1'b0;
    check("rst2_valid", out_valid, 0);
    check("rst2_rempty", rempty, 1);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    check("rst2_raempty", raempty, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_read_ctrl.md
# fifo_read_ctrl

Read-side controller for the team's FIFO memory: owns the read pointer, the empty flag and a one-word output register feeding a valid/ready consumer. Sits entirely in the read clock domain. Its inputs are the write pointer, already Gray-coded and two-flop synchronized into `rclk`, and the memory's combinational read data. Its outputs are the memory read address and the Gray read pointer for synchronization back to the write side.

## Interface
Parameters:
- `DATA_SIZE`, 8, word width
- `ADDR_SIZE`, 4, memory address width; depth = 2^ADDR_SIZE

Ports:
- `rclk`  in  1  read clock; all state updates on rising edge
- `rrst`  in  1  reset; synchronous, active-high
- `rq2_wptr`  in  ADDR_SIZE+1  synchronized Gray write pointer
- `rdata`  in  DATA_SIZE  memory read data; combinational function of `raddr`
- `raddr`  out  ADDR_SIZE  memory read address = low bits of binary read pointer
- `rptr`  out  ADDR_SIZE+1  Gray read pointer, registered, to write-domain synchronizer
- `rempty`  out  1  memory holds no unread word, registered
- `rlevel`  out  ADDR_SIZE+1  words in memory not yet fetched, registered, 0..DEPTH
- `out_data`  out  DATA_SIZE  output word, registered
- `out_valid`  out  1  `out_data` holds a word
- `out_ready`  in  1  consumer accepts `out_data` this cycle

## Operation
- State: binary read pointer `rbin` (ADDR_SIZE+1 bits, MSB is the wrap bit), `rptr`, `rempty`, `rlevel`, output register (`out_data`, `out_valid`).
- `fetch = !rempty && (!out_valid || out_ready)`. This is evaluated on registered `rempty`, never on a combinational compare.
- On `fetch`:
  - `out_data <= rdata` (the word at the current `raddr`).
  - `rbin <= rbin + 1`, which wraps modulo 2^(ADDR_SIZE+1).
- `out_valid <= fetch | (out_valid & !out_ready)`.
- `out_data` holds its value while `out_valid && !out_ready`.
- `rbinnext = rbin + fetch` and `rgraynext = (rbinnext>>1) ^ rbinnext`.
  - `rptr <= rgraynext`
  - `rempty <= (rgraynext == rq2_wptr)`
- `rlevel <= gray2bin(rq2_wptr) - rbinnext`, computed modulo 2^(ADDR_SIZE+1).
- `raddr = rbin[ADDR_SIZE-1:0]`, driven combinationally from the register.
- Empty: when `rempty=1` there is no fetch and no pointer movement. Underflow is impossible by construction.
- Wrap-around: the pointer MSB toggles every DEPTH reads. The empty compare includes the MSB, so `rlevel`=DEPTH, meaning memory full, is distinct from 0.
- Simultaneous accept and fetch: the consumer takes the old word and the new word loads in the same edge. The block sustains 1 word/cycle.
- `out_ready` while `out_valid=0` is ignored.
- The block never drives `out_valid` low without a handshake.
- Reset applies regardless of in-flight words. The pending output word is discarded and the write side must be reset together with this block.

## Timing
- Reset values (after the first `rclk` edge with `rrst=1`):
  - `rbin`=0, `rptr`=0, `raddr`=0
  - `rempty`=1, `rlevel`=0
  - `out_valid`=0, `out_data`=0
- Write-pointer latency: `rq2_wptr` changes before edge E0 → `rempty` falls after E0 → fetch at E1 → `out_valid`=1 after E1, i.e. 2 `rclk` edges.
- `rptr` reflects a fetch at the same edge that loads `out_data`.
- Last word: a fetch whose `rgraynext` equals `rq2_wptr` sets `rempty` at that same edge. A back-to-back fetch is therefore never issued on stale data.
- No combinational path from `out_ready` to `out_valid`/`out_data`.
- Only combinational path: `rbin` → `raddr`; `rdata` is sampled at the edge.

## Configuration
- `FIFO_RD_ALMOST_EMPTY_EN` defined:
  - Adds parameter `AE_LEVEL` (default 2) and output `raempty` (1 bit, registered).
  - `raempty <= (gray2bin(rq2_wptr) - rbinnext) <= AE_LEVEL`.
  - Resets to 1.
- Not defined: no `AE_LEVEL` parameter, no `raempty` port. All other behaviour is identical.

## Test plan
- Reset: hold `rrst`=1 for 3 edges with `rq2_wptr`=5'b00011 → `rempty`=1, `out_valid`=0, `rptr`=0, `raddr`=0 every cycle.
- Single word: model memory with mem[0]=8'hA5; set `rq2_wptr`=Gray(1)=5'b00001 → `rempty`=0 one edge later, `out_valid`=1 with `out_data`=8'hA5 one edge after that; `rempty`=1, `rptr`=5'b00001, `rlevel`=0.
- Streaming: 16 words (mem[i]=i), `rq2_wptr`=Gray(16)=5'b11000, `out_ready`=1 → `out_data` 0..15 on consecutive cycles, `rlevel` counts 16→0, final `rptr`=5'b11000.
- Backpressure: 4 words queued, `out_ready`=0 for 5 cycles → `out_data` holds word 0, `rptr` frozen at Gray(1), `rlevel`=3; release → words 1..3 follow with no gap.
- Wrap: preset by streaming 30 words, then 4 more spanning index 31→32 → `raddr` 15→0, MSB of `rbin` toggles, data order intact, `rempty`=1 only after word 33.
- Macro: with `FIFO_RD_ALMOST_EMPTY_EN`, `AE_LEVEL`=2: fill 4 words → `raempty`=0; after two fetches `rlevel`=2 and `raempty`=1; after reset `raempty`=1.
